// File: rtl/dvp_frame_ctrl.sv
// dvp_frame_ctrl: frame-level capture sequencer between the pixel FIFO and the
// DVP pixel-pairing state machine.
//   - Drops stream words until a VSYNC-marked word is seen, then passes bytes
//     through while checking line length and line count against the geometry.
//   - Single-shot, N-frame or continuous capture, with graceful stop.
//   - Aborted frames with an odd byte count get one zero pad word so the
//     downstream byte pairing stays aligned.
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   pxl_info_*_i/_o    upstream (FIFO) and downstream (pairing FSM) valid/ready streams
//   cam_en_o           camera-start enable, set on the first accepted start
//   cfg_*              start/stop pulses, capture mode, frame count, geometry
//   busy_o             state is not IDLE
//   frame_done_o/err_o one-cycle pulse per completed/aborted frame
//   frame_cnt_o        frames completed since the last accepted start (wraps)
module dvp_frame_ctrl #(
    parameter int unsigned DVP_DATA_W = 8,
    parameter int unsigned PXL_INFO_W = DVP_DATA_W + 2,
    parameter int unsigned DIM_W      = 11,
    parameter int unsigned FRM_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PXL_INFO_W-1:0] pxl_info_i,
    input  logic                  pxl_info_vld_i,
    output logic                  pxl_info_rdy_o,
    output logic [PXL_INFO_W-1:0] pxl_info_o,
    output logic                  pxl_info_vld_o,
    input  logic                  pxl_info_rdy_i,
    output logic                  cam_en_o,
    input  logic                  cfg_start_i,
    input  logic                  cfg_stop_i,
    input  logic                  cfg_cont_i,
    input  logic [FRM_CNT_W-1:0]  cfg_frame_num_i,
    input  logic [DIM_W-1:0]      cfg_width_i,
    input  logic [DIM_W-1:0]      cfg_height_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  frame_err_o,
    output logic [FRM_CNT_W-1:0]  frame_cnt_o
);

    localparam int unsigned HS_BIT = DVP_DATA_W;
    localparam int unsigned VS_BIT = DVP_DATA_W + 1;
    localparam int unsigned BC_W   = DIM_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_CAPT = 2'd2,
        S_PAD  = 2'd3
    } state_e;

    state_e                 state_q,     state_d;
    logic [BC_W-1:0]        bc_q,        bc_d;
    logic [DIM_W-1:0]       lc_q,        lc_d;
    logic [DIM_W-1:0]       width_q,     width_d;
    logic [DIM_W-1:0]       height_q,    height_d;
    logic [FRM_CNT_W-1:0]   num_q,       num_d;
    logic                   cont_q,      cont_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   cam_en_q,    cam_en_d;
    logic                   done_q,      done_d;
    logic                   err_q,       err_d;
    logic [FRM_CNT_W-1:0]   cnt_q,       cnt_d;

    logic                   stop_eff;
    logic                   exp_vs;
    logic                   exp_hs;
    logic                   mismatch;
    logic [BC_W-1:0]        bc_last;
    logic [FRM_CNT_W-1:0]   cnt_inc;

    // Next-state, counter and stream-path logic
    always_comb begin
        state_d        = state_q;
        bc_d           = bc_q;
        lc_d           = lc_q;
        width_d        = width_q;
        height_d       = height_q;
        num_d          = num_q;
        cont_d         = cont_q;
        stop_pend_d    = stop_pend_q;
        cam_en_d       = cam_en_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        cnt_d          = cnt_q;
        pxl_info_o     = '0;
        pxl_info_vld_o = 1'b0;
        pxl_info_rdy_o = 1'b0;

        // A stop arriving during CAPT/PAD counts immediately for this cycle's exit
        stop_eff = stop_pend_q | cfg_stop_i;
        // Expected marker: VSYNC on frame's first byte, HSYNC on each later line's first byte
        exp_vs   = (bc_q == '0) && (lc_q == '0);
        exp_hs   = (bc_q == '0) && (lc_q != '0);
        mismatch = pxl_info_vld_i &&
                   ((pxl_info_i[VS_BIT] != exp_vs) || (pxl_info_i[HS_BIT] != exp_hs));
        bc_last  = BC_W'({width_q, 1'b0}) - BC_W'(1);
        cnt_inc  = cnt_q + FRM_CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                pxl_info_rdy_o = 1'b1;
                if (cfg_start_i && (cfg_width_i != '0) && (cfg_height_i != '0)) begin
                    width_d     = cfg_width_i;
                    height_d    = cfg_height_i;
                    cont_d      = cfg_cont_i;
                    num_d       = (cfg_frame_num_i == '0) ? FRM_CNT_W'(1) : cfg_frame_num_i;
                    cnt_d       = '0;
                    stop_pend_d = 1'b0;
                    cam_en_d    = 1'b1;
                    state_d     = S_SYNC;
                end
            end

            S_SYNC: begin
                // The VSYNC word is left in the FIFO so CAPT passes it on
                if (pxl_info_vld_i && pxl_info_i[VS_BIT]) begin
                    pxl_info_rdy_o = 1'b0;
                    state_d        = S_CAPT;
                    bc_d           = '0;
                    lc_d           = '0;
                end else begin
                    pxl_info_rdy_o = 1'b1;
                end
                if (cfg_stop_i) begin
                    state_d = S_IDLE;
                end
            end

            S_CAPT: begin
                stop_pend_d    = stop_eff;
                pxl_info_o     = pxl_info_i;
                pxl_info_vld_o = pxl_info_vld_i;
                pxl_info_rdy_o = pxl_info_rdy_i;
                if (mismatch) begin
                    pxl_info_vld_o = 1'b0;
                    pxl_info_rdy_o = 1'b0;
                    err_d          = 1'b1;
                    // Odd byte count leaves a half pair downstream; pad it first
                    if (bc_q[0]) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = stop_eff ? S_IDLE : S_SYNC;
                    end
                end else if (pxl_info_vld_i && pxl_info_rdy_i) begin
                    if (bc_q == bc_last) begin
                        bc_d = '0;
                        lc_d = lc_q + DIM_W'(1);
                        if (lc_q == (height_q - DIM_W'(1))) begin
                            done_d = 1'b1;
                            cnt_d  = cnt_inc;
                            lc_d   = '0;
                            if (stop_eff || (!cont_q && (cnt_inc == num_q))) begin
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_SYNC;
                            end
                        end
                    end else begin
                        bc_d = bc_q + BC_W'(1);
                    end
                end
            end

            S_PAD: begin
                stop_pend_d    = stop_eff;
                pxl_info_vld_o = 1'b1;
                if (pxl_info_rdy_i) begin
                    state_d = stop_eff ? S_IDLE : S_SYNC;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bc_q        <= '0;
            lc_q        <= '0;
            width_q     <= '0;
            height_q    <= '0;
            num_q       <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            cam_en_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bc_q        <= bc_d;
            lc_q        <= lc_d;
            width_q     <= width_d;
            height_q    <= height_d;
            num_q       <= num_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            cam_en_q    <= cam_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cam_en_o     = cam_en_q;
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;
    assign frame_cnt_o  = cnt_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dvp_frame_ctrl.sv
// Directed bench for dvp_frame_ctrl: drives the upstream stream word by word,
// collects every downstream handshake and frame pulse, and checks against
// hand-computed expected sequences.
module tb_dvp_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pxl_info_i;
    logic        pxl_info_vld_i;
    logic        pxl_info_rdy_o;
    logic [9:0]  pxl_info_o;
    logic        pxl_info_vld_o;
    wire         pxl_info_rdy_i;
    logic        cam_en_o;
    logic        cfg_start_i;
    logic        cfg_stop_i;
    logic        cfg_cont_i;
    logic [7:0]  cfg_frame_num_i;
    logic [10:0] cfg_width_i;
    logic [10:0] cfg_height_i;
    logic        busy_o;
    logic        frame_done_o;
    logic        frame_err_o;
    logic [7:0]  frame_cnt_o;

    int nvec = 0;
    int nmis = 0;

    logic tog_en = 1'b0;
    logic tog_ph = 1'b0;
    assign pxl_info_rdy_i = tog_en ? tog_ph : 1'b1;

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        tog_ph = ~tog_ph;
    end

    dvp_frame_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .pxl_info_i      (pxl_info_i),
        .pxl_info_vld_i  (pxl_info_vld_i),
        .pxl_info_rdy_o  (pxl_info_rdy_o),
        .pxl_info_o      (pxl_info_o),
        .pxl_info_vld_o  (pxl_info_vld_o),
        .pxl_info_rdy_i  (pxl_info_rdy_i),
        .cam_en_o        (cam_en_o),
        .cfg_start_i     (cfg_start_i),
        .cfg_stop_i      (cfg_stop_i),
        .cfg_cont_i      (cfg_cont_i),
        .cfg_frame_num_i (cfg_frame_num_i),
        .cfg_width_i     (cfg_width_i),
        .cfg_height_i    (cfg_height_i),
        .busy_o          (busy_o),
        .frame_done_o    (frame_done_o),
        .frame_err_o     (frame_err_o),
        .frame_cnt_o     (frame_cnt_o)
    );

    // Downstream monitor, sampled mid-cycle when everything is settled
    logic [9:0] out_q[$];
    int done_cnt = 0;
    int err_cnt  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (pxl_info_vld_o && pxl_info_rdy_i) out_q.push_back(pxl_info_o);
            if (frame_done_o) done_cnt++;
            if (frame_err_o)  err_cnt++;
        end
    end

    logic [9:0] exp_q[$];
    int base_out;
    int base_done;
    int base_err;

    function automatic logic [9:0] vw(input logic [7:0] d); return {2'b10, d}; endfunction
    function automatic logic [9:0] hw(input logic [7:0] d); return {2'b01, d}; endfunction
    function automatic logic [9:0] dw(input logic [7:0] d); return {2'b00, d}; endfunction

    function automatic logic [9:0] get_out(input int i);
        if (i < out_q.size()) return out_q[i];
        return 10'h3ff;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        base_out  = out_q.size();
        base_done = done_cnt;
        base_err  = err_cnt;
        exp_q.delete();
    endtask

    task automatic chk_stream(input string tag, input int dn, input int er);
        chk({tag, "_nwords"}, 32'(out_q.size() - base_out), 32'(exp_q.size()));
        foreach (exp_q[i]) chk($sformatf("%s_w%0d", tag, i), 32'(get_out(base_out + i)), 32'(exp_q[i]));
        chk({tag, "_done"}, 32'(done_cnt - base_done), 32'(dn));
        chk({tag, "_err"},  32'(err_cnt - base_err),   32'(er));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until the DUT accepts it (bounded)
    task automatic send(input logic [9:0] w);
        int   t;
        logic acc;
        pxl_info_i     = w;
        pxl_info_vld_i = 1'b1;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = pxl_info_rdy_o;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk($sformatf("send_timeout_%0h", w), 32'(acc), 32'd1);
        pxl_info_vld_i = 1'b0;
    endtask

    task automatic start(input logic cont, input logic [7:0] num, input logic [10:0] w, input logic [10:0] h);
        cfg_cont_i      = cont;
        cfg_frame_num_i = num;
        cfg_width_i     = w;
        cfg_height_i    = h;
        cfg_start_i     = 1'b1;
        cyc(1);
        cfg_start_i     = 1'b0;
    endtask

    task automatic stop_pulse();
        cfg_stop_i = 1'b1;
        cyc(1);
        cfg_stop_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r1;
        rst = 1'b1;
        pxl_info_i = '0;
        pxl_info_vld_i = 1'b0;
        cfg_start_i = 1'b0;
        cfg_stop_i = 1'b0;
        cfg_cont_i = 1'b0;
        cfg_frame_num_i = '0;
        cfg_width_i = '0;
        cfg_height_i = '0;
        cyc(3);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy",  32'(busy_o),         32'd0);
        chk("rst_camen", 32'(cam_en_o),       32'd0);
        chk("rst_cnt",   32'(frame_cnt_o),    32'd0);
        chk("rst_done",  32'(frame_done_o),   32'd0);
        chk("rst_err",   32'(frame_err_o),    32'd0);
        chk("rst_vld",   32'(pxl_info_vld_o), 32'd0);
        chk("rst_rdy",   32'(pxl_info_rdy_o), 32'd1);
        cyc(1);

        // Zero geometry start is ignored
        start(1'b0, 8'd1, 11'd0, 11'd2);
        chk("zero_geom_busy", 32'(busy_o), 32'd0);

        // Single frame, junk dropped before VSYNC
        mark();
        start(1'b0, 8'd1, 11'd2, 11'd2);
        chk("t1_busy",  32'(busy_o),   32'd1);
        chk("t1_camen", 32'(cam_en_o), 32'd1);
        send(dw(8'h11)); send(dw(8'h12)); send(dw(8'h13));
        send(vw(8'h20)); send(dw(8'h21)); send(dw(8'h22)); send(dw(8'h23));
        send(hw(8'h24)); send(dw(8'h25)); send(dw(8'h26)); send(dw(8'h27));
        cyc(2);
        exp_q = '{10'h220, 10'h021, 10'h022, 10'h023, 10'h124, 10'h025, 10'h026, 10'h027};
        chk_stream("t1", 1, 0);
        chk("t1_cnt",  32'(frame_cnt_o), 32'd1);
        chk("t1_busy_end", 32'(busy_o), 32'd0);

        // Error at odd byte count: one pad word, then a clean frame
        mark();
        start(1'b0, 8'd1, 11'd2, 11'd2);
        chk("t2_cnt_clr", 32'(frame_cnt_o), 32'd0);
        send(vw(8'h30)); send(dw(8'h31)); send(dw(8'h32)); send(hw(8'h33));
        send(vw(8'h34)); send(dw(8'h35)); send(dw(8'h36)); send(dw(8'h37));
        send(hw(8'h38)); send(dw(8'h39)); send(dw(8'h3a)); send(dw(8'h3b));
        cyc(2);
        exp_q = '{10'h230, 10'h031, 10'h032, 10'h000, 10'h234, 10'h035, 10'h036, 10'h037,
                  10'h138, 10'h039, 10'h03a, 10'h03b};
        chk_stream("t2", 1, 1);

        // Error at even byte count: no pad word
        mark();
        start(1'b0, 8'd1, 11'd2, 11'd2);
        send(vw(8'h40)); send(dw(8'h41)); send(hw(8'h42));
        send(vw(8'h44)); send(dw(8'h45)); send(dw(8'h46)); send(dw(8'h47));
        send(hw(8'h48)); send(dw(8'h49)); send(dw(8'h4a)); send(dw(8'h4b));
        cyc(2);
        exp_q = '{10'h240, 10'h041, 10'h244, 10'h045, 10'h046, 10'h047,
                  10'h148, 10'h049, 10'h04a, 10'h04b};
        chk_stream("t3", 1, 1);

        // N-frame mode: 3 of 5 frames captured
        mark();
        start(1'b0, 8'd3, 11'd1, 11'd1);
        for (int i = 0; i < 5; i++) begin
            send(vw(8'(8'h70 + 2 * i)));
            send(dw(8'(8'h71 + 2 * i)));
        end
        cyc(2);
        exp_q = '{10'h270, 10'h071, 10'h272, 10'h073, 10'h274, 10'h075};
        chk_stream("t4", 3, 0);
        chk("t4_cnt",  32'(frame_cnt_o), 32'd3);
        chk("t4_busy", 32'(busy_o),      32'd0);

        // Continuous mode, then stop mid-frame lets the frame finish
        mark();
        start(1'b1, 8'd0, 11'd2, 11'd2);
        send(vw(8'h80)); send(dw(8'h81)); send(dw(8'h82)); send(dw(8'h83));
        send(hw(8'h84)); send(dw(8'h85)); send(dw(8'h86)); send(dw(8'h87));
        cyc(1);
        chk("t5_busy_cont", 32'(busy_o),      32'd1);
        chk("t5_cnt1",      32'(frame_cnt_o), 32'd1);
        send(vw(8'h50)); send(dw(8'h51));
        stop_pulse();
        chk("t5_busy_pend", 32'(busy_o), 32'd1);
        send(dw(8'h52)); send(dw(8'h53)); send(hw(8'h54)); send(dw(8'h55));
        send(dw(8'h56)); send(dw(8'h57));
        cyc(2);
        exp_q = '{10'h280, 10'h081, 10'h082, 10'h083, 10'h184, 10'h085, 10'h086, 10'h087,
                  10'h250, 10'h051, 10'h052, 10'h053, 10'h154, 10'h055, 10'h056, 10'h057};
        chk_stream("t5", 2, 0);
        chk("t5_cnt2",     32'(frame_cnt_o), 32'd2);
        chk("t5_busy_end", 32'(busy_o),      32'd0);

        // Stop in SYNC returns to IDLE after one cycle
        start(1'b1, 8'd0, 11'd2, 11'd2);
        chk("t5s_busy", 32'(busy_o),      32'd1);
        chk("t5s_cnt",  32'(frame_cnt_o), 32'd0);
        stop_pulse();
        chk("t5s_idle", 32'(busy_o), 32'd0);

        // Downstream ready toggling through CAPT and PAD
        mark();
        tog_en = 1'b1;
        start(1'b0, 8'd1, 11'd1, 11'd1);
        send(vw(8'h60));
        @(negedge clk);
        r1 = pxl_info_rdy_i;
        chk("t6_track_a", 32'(pxl_info_rdy_o), 32'(r1));
        @(negedge clk);
        chk("t6_track_b", 32'(pxl_info_rdy_o), 32'(pxl_info_rdy_i));
        chk("t6_vld_idle", 32'(pxl_info_vld_o), 32'd0);
        cyc(1);
        send(hw(8'h61));
        send(vw(8'h62)); send(dw(8'h63));
        cyc(3);
        tog_en = 1'b0;
        exp_q = '{10'h260, 10'h000, 10'h262, 10'h063};
        chk_stream("t6", 1, 1);
        chk("t6_cnt",  32'(frame_cnt_o), 32'd1);
        chk("t6_busy", 32'(busy_o),      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/dvp_frame_ctrl.md
Name: dvp_frame_ctrl

Overview:
- Frame-level capture sequencer between the pixel FIFO and the DVP pixel-pairing state machine.
- Drops stream data until a frame start, then passes bytes through while checking line length and line count against the configured geometry.
- Supports single-shot, N-frame and continuous capture with graceful stop.
- Keeps the downstream byte pairing aligned by padding aborted frames to an even byte count, and drives the camera-start enable of the pairing state machine.

Parameters:
- DVP_DATA_W, 8, pixel byte width.
- PXL_INFO_W, DVP_DATA_W+2, stream word width: [DVP_DATA_W-1:0] data, [DVP_DATA_W] HSYNC marker, [DVP_DATA_W+1] VSYNC marker.
- DIM_W, 11, width of the geometry fields (pixels per line, lines per frame).
- FRM_CNT_W, 8, width of the frame number and frame counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- pxl_info_i  in  PXL_INFO_W  upstream stream word from the pixel FIFO.
- pxl_info_vld_i  in  1  upstream valid.
- pxl_info_rdy_o  out  1  upstream ready.
- pxl_info_o  out  PXL_INFO_W  downstream stream word.
- pxl_info_vld_o  out  1  downstream valid.
- pxl_info_rdy_i  in  1  downstream ready.
- cam_en_o  out  1  camera-start enable to the pairing state machine.
- cfg_start_i  in  1  start pulse.
- cfg_stop_i  in  1  stop pulse.
- cfg_cont_i  in  1  1 = continuous capture.
- cfg_frame_num_i  in  FRM_CNT_W  frames to capture when not continuous; 0 is treated as 1.
- cfg_width_i  in  DIM_W  pixels per line (2 bytes per pixel).
- cfg_height_i  in  DIM_W  lines per frame.
- busy_o  out  1  high whenever the state is not IDLE.
- frame_done_o  out  1  one-cycle pulse per completed frame.
- frame_err_o  out  1  one-cycle pulse per aborted frame.
- frame_cnt_o  out  FRM_CNT_W  frames completed since the last accepted start; wraps.

Behaviour:
- Reset (synchronous): state IDLE; all counters 0; stop_pend 0. Outputs: cam_en_o 0, frame_done_o 0, frame_err_o 0, frame_cnt_o 0, pxl_info_vld_o 0. In IDLE after reset, pxl_info_rdy_o is 1.
- Reset mid-frame abandons the frame without padding. Realigning downstream is the system reset's responsibility.
- Start accept: cfg_start_i in IDLE with width != 0 and height != 0.
  - Latches cfg_cont_i, cfg_frame_num_i, width and height.
  - Clears frame_cnt_o and stop_pend; sets cam_en_o (sticky until reset).
  - Next state SYNC.
  - Start while busy, or with zero geometry, is ignored.
- State IDLE: rdy_o = 1, vld_o = 0. All input is drained and discarded.
- State SYNC: vld_o = 0.
  - A word without VSYNC: rdy_o = 1, word discarded.
  - Valid word with VSYNC: rdy_o = 0 (word not consumed); next state CAPT with byte count bc = 0, line count lc = 0.
- State CAPT: combinational pass-through. pxl_info_o = pxl_info_i; vld_o = vld_i; rdy_o = rdy_i. Counters advance only on downstream handshake.
- Marker check, applied to the valid word in CAPT:
  - Expected marker is VSYNC when bc == 0 and lc == 0, HSYNC when bc == 0 and lc > 0, none when bc != 0.
  - A mismatch is an error.
- On error:
  - The offending word is not passed: vld_o = 0, rdy_o = 0.
  - frame_err_o pulses next cycle.
  - Next state is PAD if bc[0] == 1, else SYNC, or IDLE if stop_pend.
- Line end: handshake with bc == 2*width-1 sets bc to 0 and increments lc.
- Frame end: line end with lc == height-1.
  - frame_done_o pulses next cycle; frame_cnt_o increments.
  - Next state is IDLE if stop_pend, or if not continuous and frame_cnt+1 == frame_num; otherwise SYNC.
- State PAD:
  - vld_o = 1, pxl_info_o = all zeros, rdy_o = 0.
  - On rdy_i: next state SYNC, or IDLE if stop_pend.
- Stop:
  - cfg_stop_i in SYNC goes to IDLE next cycle.
  - In CAPT or PAD it sets stop_pend; the frame completes, or the abort path runs, then the state goes to IDLE.
  - cfg_stop_i in IDLE is ignored.
  - Start and stop in the same IDLE cycle: start wins, stop is ignored.
- Frame-end and error events are mutually exclusive per cycle, because an error blocks the handshake.
- Counters: bc is DIM_W+1 bits, lc is DIM_W bits. No overflow occurs within the configured geometry.

Test Plan:
- W=2, H=2, cont=0, num=1. Stream 3 marker-free bytes, then VSYNC byte, 3 bytes, HSYNC byte, 3 bytes -> 3 junk bytes dropped; 8 bytes passed in order; frame_done_o one pulse; frame_cnt_o = 1; state IDLE; busy_o 0.
- W=2, H=2. VSYNC byte, 2 bytes, then HSYNC at bc=3 -> frame_err_o pulse; one 0x000 PAD word emitted; SYNC; the next VSYNC frame completes normally.
- Same as above but error at bc=2 -> no PAD word; direct SYNC.
- cont=0, num=3, W=1, H=1. Five back-to-back frames -> exactly 3 frame_done_o pulses; frame_cnt_o = 3; frames 4 and 5 dropped in IDLE.
- cont=1. cfg_stop_i mid-frame -> current frame completes with frame_done_o, then IDLE. A stop in SYNC returns to IDLE in 1 cycle.
- Downstream rdy_i toggling 1010… during CAPT and PAD -> no lost or duplicated words; counters advance only on handshake; pxl_info_rdy_o tracks pxl_info_rdy_i.
